// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//  - Stage occupancy encodings used by pipe_stage_reg.
//  - ID/EX control-vector field offsets and widths.
//  - CTRL_NOP: the control value that makes a stage behave as a bubble.
package pipe_pkg;

    // Stage occupancy: no entry, head entry only, head plus skid entry.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID2 = 2'd2;

    // ID/EX control vector layout (8 bits total).
    localparam int CTRL_IDEX_W     = 8;
    localparam int CTRL_REGDST_O   = 0;
    localparam int CTRL_ALUOP_O    = 1;
    localparam int CTRL_ALUOP_W    = 2;
    localparam int CTRL_ALUSRC_O   = 3;
    localparam int CTRL_REGWRITE_O = 4;
    localparam int CTRL_MEMTOREG_O = 5;
    localparam int CTRL_MEMREAD_O  = 6;
    localparam int CTRL_MEMWRITE_O = 7;

    // All write/memory enables low: a NOP travelling down the pipe.
    localparam logic [CTRL_IDEX_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//  clk_i  : clock
//  rst_i  : asynchronous active-high reset, clears the count
//  inc_i  : increment request for this cycle
//  cnt_o  : current count; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake.
//  clk_i, rst_i            : clock, asynchronous active-high reset
//  up_valid_i/up_ready_o   : upstream handshake
//  data_i, ctrl_i          : upstream payload and control vector
//  flush_i                 : synchronous kill of every held entry
//  dn_valid_o/dn_ready_i   : downstream handshake
//  data_o, ctrl_o          : head entry (ctrl_o is CTRL_BUBBLE when not valid)
//  stall_cnt_o             : saturating count of downstream stall cycles
//  flush_cnt_o             : saturating count of flushes that killed an entry
// SKID=1 gives a 2-entry skid buffer with a registered up_ready_o;
// SKID=0 gives a single register with combinational ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 160,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
    parameter bit                 SKID        = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              in_fire;
    logic              out_fire;

    assign dn_valid_o = (state_q != EMPTY);
    assign in_fire    = up_valid_i & up_ready_o;
    assign out_fire   = dn_valid_o & dn_ready_i;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] s_data_q, s_data_d;
            logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
            logic              up_ready_q, up_ready_d;

            always_comb begin
                state_d  = state_q;
                m_data_d = m_data_q;
                m_ctrl_d = m_ctrl_q;
                s_data_d = s_data_q;
                s_ctrl_d = s_ctrl_q;
                if (flush_i) begin
                    // Flush beats everything, including a same-cycle out_fire.
                    state_d  = EMPTY;
                    m_ctrl_d = CTRL_BUBBLE;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d  = FULL;
                                m_data_d = data_i;
                                m_ctrl_d = ctrl_i;
                            end
                        end
                        FULL: begin
                            if (in_fire && out_fire) begin
                                m_data_d = data_i;
                                m_ctrl_d = ctrl_i;
                            end else if (in_fire) begin
                                // Ready was promised a cycle ago; park the entry.
                                state_d  = SKID2;
                                s_data_d = data_i;
                                s_ctrl_d = ctrl_i;
                            end else if (out_fire) begin
                                state_d  = EMPTY;
                                m_ctrl_d = CTRL_BUBBLE;
                            end
                        end
                        SKID2: begin
                            if (out_fire) begin
                                state_d  = FULL;
                                m_data_d = s_data_q;
                                m_ctrl_d = s_ctrl_q;
                            end
                        end
                        default: begin
                            state_d  = EMPTY;
                            m_ctrl_d = CTRL_BUBBLE;
                        end
                    endcase
                end
                up_ready_d = (state_d != SKID2);
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s_data_q   <= '0;
                    s_ctrl_q   <= '0;
                    up_ready_q <= 1'b1;
                end else begin
                    s_data_q   <= s_data_d;
                    s_ctrl_q   <= s_ctrl_d;
                    up_ready_q <= up_ready_d;
                end
            end

            assign up_ready_o = up_ready_q;
        end else begin : g_single
            assign up_ready_o = dn_ready_i | ~dn_valid_o;

            always_comb begin
                state_d  = state_q;
                m_data_d = m_data_q;
                m_ctrl_d = m_ctrl_q;
                if (flush_i) begin
                    state_d  = EMPTY;
                    m_ctrl_d = CTRL_BUBBLE;
                end else if (in_fire) begin
                    state_d  = FULL;
                    m_data_d = data_i;
                    m_ctrl_d = ctrl_i;
                end else if (out_fire) begin
                    state_d  = EMPTY;
                    m_ctrl_d = CTRL_BUBBLE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= CTRL_BUBBLE;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
        end
    end

    assign data_o = m_data_q;
    assign ctrl_o = m_ctrl_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (dn_valid_o & ~dn_ready_i),
        .cnt_o (stall_cnt_o)
    );

    // Only flushes that actually drop a held entry are counted.
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_i & dn_valid_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 stage with 4-bit counters and a
// SKID=0 stage checked against a single-register reference model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic          a_up_valid, a_up_ready, a_flush, a_dn_valid, a_dn_ready;
    logic [DW-1:0] a_data_i, a_data_o;
    logic [CW-1:0] a_ctrl_i, a_ctrl_o;
    logic [3:0]    a_stall, a_flushc;

    // SKID=0 instance
    logic          b_up_valid, b_up_ready, b_flush, b_dn_valid, b_dn_ready;
    logic [DW-1:0] b_data_i, b_data_o;
    logic [CW-1:0] b_ctrl_i, b_ctrl_o;
    logic [15:0]   b_stall, b_flushc;

    int tests = 0;
    int failures = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .SKID(1'b1), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .up_valid_i(a_up_valid), .up_ready_o(a_up_ready),
        .data_i(a_data_i), .ctrl_i(a_ctrl_i), .flush_i(a_flush),
        .dn_valid_o(a_dn_valid), .dn_ready_i(a_dn_ready),
        .data_o(a_data_o), .ctrl_o(a_ctrl_o),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flushc)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .SKID(1'b0), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .up_valid_i(b_up_valid), .up_ready_o(b_up_ready),
        .data_i(b_data_i), .ctrl_i(b_ctrl_i), .flush_i(b_flush),
        .dn_valid_o(b_dn_valid), .dn_ready_i(b_dn_ready),
        .data_o(b_data_o), .ctrl_o(b_ctrl_o),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flushc)
    );

    function automatic logic [CW-1:0] ctl(input logic [DW-1:0] d);
        return d[7:0] + 8'h40;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus to the SKID=1 stage, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
        a_up_valid = v;
        a_data_i   = d;
        a_ctrl_i   = ctl(d);
        a_dn_ready = rdy;
        a_flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [DW-1:0] ed, input logic er);
        chk({tag, ".dn_valid"}, 32'(a_dn_valid), 32'(ev));
        chk({tag, ".data_o"},   a_data_o, ed);
        chk({tag, ".up_ready"}, 32'(a_up_ready), 32'(er));
        chk({tag, ".ctrl_o"},   32'(a_ctrl_o), ev ? 32'(ctl(ed)) : 32'h0);
        $display("[TB] %s: valid=%0d data=%0h ready=%0d ctrl=%0h", tag, a_dn_valid, a_data_o, a_up_ready, a_ctrl_o);
    endtask

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [15:0]   m_stall;
    logic          exp_ready;

    initial begin
        rst = 1'b1;
        a_up_valid = 0; a_data_i = '0; a_ctrl_i = '0; a_flush = 0; a_dn_ready = 0;
        b_up_valid = 0; b_data_i = '0; b_ctrl_i = '0; b_flush = 0; b_dn_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk_a("reset", 1'b0, 32'h0, 1'b1);
        chk("reset.stall", 32'(a_stall), 32'h0);
        chk("reset.flushcnt", 32'(a_flushc), 32'h0);
        chk("reset.b_ready", 32'(b_up_ready), 32'h1);

        // 1: single transfer, one-cycle latency; drain loads bubble and keeps data
        drive(1, 32'hA5A5A5A5, 1, 0); chk_a("t1.load", 1, 32'hA5A5A5A5, 1);
        drive(0, 32'h0, 1, 0);        chk_a("t1.drain", 0, 32'hA5A5A5A5, 1);

        // 2: stream 1..4, downstream stalls in cycles 2-3
        drive(1, 1, 1, 0); chk_a("t2.c1", 1, 1, 1);
        drive(1, 2, 0, 0); chk_a("t2.c2", 1, 1, 0);
        drive(1, 3, 0, 0); chk_a("t2.c3", 1, 1, 0);
        drive(1, 3, 1, 0); chk_a("t2.c4", 1, 2, 1);
        drive(1, 3, 1, 0); chk_a("t2.c5", 1, 3, 1);
        drive(1, 4, 1, 0); chk_a("t2.c6", 1, 4, 1);
        drive(0, 0, 1, 0); chk_a("t2.c7", 0, 4, 1);
        chk("t2.stall", 32'(a_stall), 32'd2);

        // 3: flush while in SKID2 with a live input
        drive(1, 5, 0, 0); chk_a("t3.c1", 1, 5, 1);
        drive(1, 6, 0, 0); chk_a("t3.c2", 1, 5, 0);
        drive(1, 7, 0, 1); chk_a("t3.flush", 0, 5, 1);
        chk("t3.flushcnt", 32'(a_flushc), 32'd1);
        chk("t3.stall", 32'(a_stall), 32'd4);
        drive(0, 0, 1, 0); chk_a("t3.after", 0, 5, 1);
        drive(1, 8, 1, 0); chk_a("t3.next", 1, 8, 1);
        drive(0, 0, 1, 0); chk_a("t3.drain", 0, 8, 1);

        // 4: flush while empty is not counted
        drive(0, 0, 1, 1); chk_a("t4.flush_empty", 0, 8, 1);
        chk("t4.flushcnt", 32'(a_flushc), 32'd1);

        // 5: stall counter saturates at 15
        drive(1, 9, 0, 0); chk_a("t5.load", 1, 9, 1);
        repeat (21) drive(0, 0, 0, 0);
        chk("t5.sat", 32'(a_stall), 32'd15);
        chk_a("t5.hold", 1, 9, 1);
        drive(0, 0, 0, 0);
        chk("t5.sat_again", 32'(a_stall), 32'd15);
        drive(0, 0, 1, 0); chk_a("t5.drain", 0, 9, 1);
        chk("t5.sat_final", 32'(a_stall), 32'd15);

        // 7: asynchronous reset mid-cycle while FULL
        drive(1, 10, 0, 0); chk_a("t7.load", 1, 10, 1);
        #2;
        rst = 1'b1;
        a_up_valid = 0;
        #1;
        chk_a("t7.async", 0, 32'h0, 1);
        chk("t7.stall", 32'(a_stall), 32'h0);
        chk("t7.flushcnt", 32'(a_flushc), 32'h0);
        #1 rst = 1'b0;
        drive(0, 0, 1, 0); chk_a("t7.after", 0, 32'h0, 1);

        // 6: SKID=0 stage, random valid/ready against a single-register model
        m_valid = 0; m_data = '0; m_stall = '0;
        for (int i = 0; i < 10000; i++) begin
            b_up_valid = 1'($urandom_range(0, 1));
            b_dn_ready = 1'($urandom_range(0, 1));
            b_data_i   = $urandom;
            b_ctrl_i   = ctl(b_data_i);
            #1;
            exp_ready = b_dn_ready | ~m_valid;
            chk("t6.ready", 32'(b_up_ready), 32'(exp_ready));
            chk("t6.valid", 32'(b_dn_valid), 32'(m_valid));
            if (m_valid) begin
                chk("t6.data", b_data_o, m_data);
                chk("t6.ctrl", 32'(b_ctrl_o), 32'(ctl(m_data)));
            end else begin
                chk("t6.bubble", 32'(b_ctrl_o), 32'h0);
            end
            if (m_valid && !b_dn_ready && m_stall != 16'hFFFF) m_stall++;
            if (b_up_valid && exp_ready) begin
                m_valid = 1'b1;
                m_data  = b_data_i;
            end else if (m_valid && b_dn_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("t6.stall", 32'(b_stall), 32'(m_stall));
        $display("[TB] t6: 10000 random cycles, stall_cnt=%0d", b_stall);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
